effect_eq_multiband: RTL and testbench

// - N-band successor to the 3-band EQ: splits the mono sample stream into NUM_BANDS bands with cascaded 2nd-order one-pole LPs,

---
 rtl/eq_pkg.sv | 30 +++
 rtl/eq_lp2_section.sv | 38 +++
 rtl/effect_eq_multiband.sv | 120 ++++++++++++
 tb/tb_effect_eq_multiband.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/eq_pkg.sv
// eq_pkg: shared types, constants and helpers for the multiband EQ
package eq_pkg;

    localparam int GAIN_W = 9;
    localparam logic signed [GAIN_W-1:0] UNITY_GAIN = 9'sd16;

    typedef enum logic [1:0] {IDLE, SPLIT, MAC, SAT} state_t;

    function automatic logic signed [GAIN_W-1:0] level_gain(input logic [2:0] level);
        case (level)
            3'd0: return 9'sd0;
            3'd1: return 9'sd4;
            3'd2: return 9'sd8;
            3'd3: return 9'sd12;
            3'd4: return 9'sd16;
            3'd5: return 9'sd24;
            3'd6: return 9'sd32;
            3'd7: return 9'sd48;
        endcase
    endfunction

    function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        return (v > hi) ? hi : (v < lo) ? lo : v;
    endfunction

endpackage

// File: rtl/eq_lp2_section.sv
// eq_lp2_section: two cascaded one-pole low-pass stages; o_lp is the value the section takes on at the next enabled edge
module eq_lp2_section #(
    parameter int W     = 17,
    parameter int SHIFT = 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_en,
    input  logic signed [W-1:0] i_x,
    output logic signed [W-1:0] o_lp
);

    logic signed [W-1:0] s1;
    logic signed [W-1:0] s2;
    logic signed [W-1:0] s1_n;
    logic signed [W:0]   d1;
    logic signed [W:0]   d2;

    // next values of both stages; the differences get one extra bit so they cannot wrap
    always_comb begin
        d1   = {i_x[W-1], i_x} - {s1[W-1], s1};
        s1_n = s1 + W'(d1 >>> SHIFT);
        d2   = {s1_n[W-1], s1_n} - {s2[W-1], s2};
        o_lp = s2 + W'(d2 >>> SHIFT);
    end

    // filter state moves only when a sample is being split
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1 <= '0;
            s2 <= '0;
        end else if (i_en) begin
            s1 <= s1_n;
            s2 <= o_lp;
        end
    end

endmodule

// File: rtl/effect_eq_multiband.sv
// effect_eq_multiband: N-band EQ with cascaded LP split, ramped per-band gains and one time-shared multiplier
module effect_eq_multiband
    import eq_pkg::*;
#(
    parameter int                         DATA_W       = 16,
    parameter int                         NUM_BANDS    = 4,
    parameter logic [4*(NUM_BANDS-1)-1:0] ALPHA_SHIFTS = {4'd4, 4'd2, 4'd1},
    parameter int                         GAIN_FRAC    = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic                     i_enable,
    input  logic [3*NUM_BANDS-1:0]   i_levels,
    input  logic signed [DATA_W-1:0] i_data,
    output logic signed [DATA_W-1:0] o_data,
    output logic                     o_valid
);

    localparam int LW = DATA_W + 1;
    localparam int BW = DATA_W + 2;
    localparam int PW = DATA_W + 11;
    localparam int AW = PW + $clog2(NUM_BANDS);
    localparam int KW = $clog2(NUM_BANDS);

    state_t                    state;
    logic [KW-1:0]             k;
    logic signed [DATA_W-1:0]  x;
    logic                      en_r;
    logic [3*NUM_BANDS-1:0]    lvl;
    logic signed [LW-1:0]      lp     [NUM_BANDS];
    logic signed [BW-1:0]      band_n [NUM_BANDS];
    logic signed [BW-1:0]      band   [NUM_BANDS];
    logic signed [GAIN_W-1:0]  gain   [NUM_BANDS];
    logic signed [GAIN_W-1:0]  tgt    [NUM_BANDS];
    logic signed [AW-1:0]      acc;
    logic signed [PW-1:0]      prod;
    logic signed [63:0]        y;
    logic                      split;

    assign split = state == SPLIT;
    assign lp[0] = {x[DATA_W-1], x};
    assign prod  = PW'(band[k]) * PW'(gain[k]);
    assign y     = 64'(acc >>> GAIN_FRAC);

    for (genvar s = 1; s < NUM_BANDS; s++) begin : g_lp
        eq_lp2_section #(
            .W     (LW),
            .SHIFT (int'(ALPHA_SHIFTS[4*(s-1) +: 4]))
        ) u_sec (
            .i_clk (i_clk),
            .i_rst (i_rst),
            .i_en  (split),
            .i_x   (lp[s-1]),
            .o_lp  (lp[s])
        );
    end

    // adjacent LP differences telescope, so the bands always sum back to x
    for (genvar b = 0; b < NUM_BANDS; b++) begin : g_band
        assign tgt[b] = level_gain(lvl[3*b +: 3]);
        if (b == NUM_BANDS - 1) begin : g_last
            assign band_n[b] = BW'(lp[b]);
        end else begin : g_mid
            assign band_n[b] = BW'(lp[b]) - BW'(lp[b+1]);
        end
    end

    // sample FSM: accept, split and ramp gains, one MAC per band, saturate and emit
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            o_ready <= 1'b1;
            o_valid <= 1'b0;
            o_data  <= '0;
            k       <= '0;
            acc     <= '0;
            x       <= '0;
            en_r    <= 1'b0;
            lvl     <= '0;
            for (int b = 0; b < NUM_BANDS; b++) begin
                gain[b] <= UNITY_GAIN;
                band[b] <= '0;
            end
        end else begin
            o_valid <= 1'b0;
            unique case (state)
                IDLE: if (i_valid) begin
                    x       <= i_data;
                    en_r    <= i_enable;
                    lvl     <= i_levels;
                    o_ready <= 1'b0;
                    state   <= SPLIT;
                end
                SPLIT: begin
                    for (int b = 0; b < NUM_BANDS; b++) begin
                        band[b] <= band_n[b];
                        gain[b] <= gain[b] + ((tgt[b] > gain[b]) ? GAIN_W'(1) : (tgt[b] < gain[b]) ? -GAIN_W'(1) : GAIN_W'(0));
                    end
                    acc   <= '0;
                    k     <= '0;
                    state <= MAC;
                end
                MAC: begin
                    acc   <= acc + AW'(prod);
                    k     <= k + KW'(1);
                    state <= (k == KW'(NUM_BANDS - 1)) ? SAT : MAC;
                end
                SAT: begin
                    o_data  <= en_r ? DATA_W'(saturate(y, DATA_W)) : x;
                    o_valid <= 1'b1;
                    o_ready <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_effect_eq_multiband.sv
// tb_effect_eq_multiband: directed checks of latency, unity transparency, gain ramps, saturation, drop and reset behaviour
module tb_effect_eq_multiband;

    localparam int DW  = 16;
    localparam int NB  = 4;
    localparam int LAT = NB + 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 valid = 1'b0;
    logic                 enable = 1'b1;
    logic [3*NB-1:0]      levels = '0;
    logic signed [DW-1:0] din = '0;
    logic signed [DW-1:0] dout;
    logic                 ready;
    logic                 vout;
    int                   errors = 0;
    int                   checks = 0;

    always #5 clk = ~clk;

    effect_eq_multiband #(.DATA_W(DW), .NUM_BANDS(NB)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_valid  (valid),
        .o_ready  (ready),
        .i_enable (enable),
        .i_levels (levels),
        .i_data   (din),
        .o_data   (dout),
        .o_valid  (vout)
    );

    function automatic logic [3*NB-1:0] all_levels(input logic [2:0] l);
        return {NB{l}};
    endfunction

    function automatic logic signed [DW-1:0] sat_ref(input longint v);
        return (v > 32767) ? 16'h7fff : (v < -32768) ? 16'h8000 : DW'(v);
    endfunction

    task automatic do_reset;
        @(negedge clk);
        rst   = 1'b1;
        valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // called at a negedge; returns at the negedge where o_valid is seen (or after the bound expires)
    task automatic do_sample(input logic signed [DW-1:0] d, output logic signed [DW-1:0] y,
                             output int lat, output logic rlow);
        int w;
        w = 0;
        while (!ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        din   = d;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        lat   = 0;
        rlow  = 1'b1;
        while (!vout && lat < 20) begin
            if (ready) rlow = 1'b0;
            @(negedge clk);
            lat++;
        end
        y = dout;
    endtask

    task automatic test_reset;
        do_reset;
        checks++; if (dout !== 16'sd0) begin errors++; $display("FAIL reset_data: got %0d want 0", dout); end
        checks++; if (vout !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", vout); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
    endtask

    task automatic test_single;
        logic signed [DW-1:0] y;
        int lat;
        logic rlow;
        levels = all_levels(3'd4);
        enable = 1'b1;
        do_sample(16'sd12345, y, lat, rlow);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL single_latency: got %0d edges want %0d", lat, LAT); end
        checks++; if (rlow !== 1'b1) begin errors++; $display("FAIL single_ready_low: got %b want 1", rlow); end
        checks++; if (y !== 16'sd12345) begin errors++; $display("FAIL single_data: got %0d want 12345", y); end
        do_sample(16'sh7fff, y, lat, rlow);
        checks++; if (lat !== LAT || y !== 16'sh7fff) begin errors++; $display("FAIL single_max: got %0d lat %0d want 32767 lat %0d", y, lat, LAT); end
        do_sample(16'sh8000, y, lat, rlow);
        checks++; if (lat !== LAT || y !== 16'sh8000) begin errors++; $display("FAIL single_min: got %0d lat %0d want -32768 lat %0d", y, lat, LAT); end
    endtask

    task automatic test_unity_stream;
        logic signed [DW-1:0] y;
        logic signed [DW-1:0] d;
        int lat;
        logic rlow;
        levels = all_levels(3'd4);
        enable = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            d = DW'($urandom);
            do_sample(d, y, lat, rlow);
            checks++;
            if (lat !== LAT || y !== d) begin errors++; $display("FAIL unity_stream[%0d]: got %0d lat %0d want %0d lat %0d", i, y, lat, d, LAT); end
        end
    endtask

    task automatic test_bypass;
        logic signed [DW-1:0] y;
        int lat;
        logic rlow;
        do_reset;
        levels = all_levels(3'd7);
        enable = 1'b0;
        do_sample(16'sd20000, y, lat, rlow);
        checks++; if (lat !== LAT || y !== 16'sd20000) begin errors++; $display("FAIL bypass_data: got %0d lat %0d want 20000 lat %0d", y, lat, LAT); end
        enable = 1'b1;
        do_sample(16'sd20000, y, lat, rlow);
        checks++; if (y !== 16'sd22500) begin errors++; $display("FAIL bypass_ramp_continues: got %0d want 22500", y); end
    endtask

    task automatic test_boost_sat;
        logic signed [DW-1:0] y;
        logic signed [DW-1:0] e;
        int lat;
        int g;
        logic rlow;
        do_reset;
        levels = all_levels(3'd7);
        enable = 1'b1;
        for (int i = 1; i <= 34; i++) begin
            g = (16 + i > 48) ? 48 : 16 + i;
            e = sat_ref(longint'(1250 * g));
            do_sample(16'sd20000, y, lat, rlow);
            checks++;
            if (lat !== LAT || y !== e) begin errors++; $display("FAIL boost[%0d]: got %0d lat %0d want %0d", i, y, lat, e); end
        end
        for (int i = 0; i < 3; i++) begin
            do_sample(-16'sd20000, y, lat, rlow);
            checks++;
            if (lat !== LAT || y !== 16'sh8000) begin errors++; $display("FAIL boost_neg[%0d]: got %0d want -32768", i, y); end
        end
    endtask

    task automatic test_cut;
        logic signed [DW-1:0] y;
        logic signed [DW-1:0] e;
        int lat;
        logic rlow;
        do_reset;
        levels = all_levels(3'd0);
        enable = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            e = DW'((16 - i > 0) ? 500 * (16 - i) : 0);
            do_sample(16'sd8000, y, lat, rlow);
            checks++;
            if (lat !== LAT || y !== e) begin errors++; $display("FAIL cut[%0d]: got %0d lat %0d want %0d", i, y, lat, e); end
        end
    endtask

    task automatic test_back_to_back;
        logic signed [DW-1:0] q[$];
        int last;
        int accepted;
        int outs;
        last = -1;
        accepted = 0;
        outs = 0;
        do_reset;
        levels = all_levels(3'd4);
        enable = 1'b1;
        for (int c = 0; c < 70; c++) begin
            if (vout) begin
                checks++;
                if (q.size() == 0 || dout !== q[0] || (last >= 0 && c - last != NB + 3)) begin
                    errors++;
                    $display("FAIL b2b_out at cycle %0d: got %0d gap %0d want %0d gap %0d", c, dout, c - last, (q.size() > 0) ? int'(q[0]) : 0, NB + 3);
                end
                if (q.size() > 0) void'(q.pop_front());
                outs++;
                last = c;
            end
            valid = (c < 50);
            din   = DW'(100 + c);
            if (valid && ready) begin
                q.push_back(din);
                accepted++;
            end
            @(negedge clk);
        end
        valid = 1'b0;
        checks++; if (accepted !== 8) begin errors++; $display("FAIL b2b_accepted: got %0d want 8", accepted); end
        checks++; if (outs !== accepted || q.size() != 0) begin errors++; $display("FAIL b2b_outputs: got %0d want %0d", outs, accepted); end
    endtask

    task automatic test_rst_mid;
        logic signed [DW-1:0] y;
        int lat;
        int seen;
        logic rlow;
        seen = 0;
        do_reset;
        levels = all_levels(3'd4);
        enable = 1'b1;
        do_sample(16'sd777, y, lat, rlow);
        din   = 16'sd9999;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (dout !== 16'sd0) begin errors++; $display("FAIL rst_mid_data: got %0d want 0", dout); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b want 1", ready); end
        for (int c = 0; c < 10; c++) begin
            if (vout) seen++;
            @(negedge clk);
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rst_mid_no_valid: got %0d pulses want 0", seen); end
        do_sample(16'sd500, y, lat, rlow);
        checks++; if (lat !== LAT || y !== 16'sd500) begin errors++; $display("FAIL rst_mid_next: got %0d lat %0d want 500 lat %0d", y, lat, LAT); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_unity_stream;
        test_bypass;
        test_boost_sat;
        test_cut;
        test_back_to_back;
        test_rst_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
